// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared types and constants for the instruction-memory
//                stream loader. Holds the loader state enum, the error
//                codes reported on the loader's error port, and small
//                decode helpers that map a state onto the status outputs.
//  Revision    : 1.0  initial release
// ============================================================================
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } loader_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_LEN     = 2'b11;

  // A load is in progress.
  function automatic logic state_busy(input loader_state_t s);
    return (s == ST_RECV) || (s == ST_WRITE) || (s == ST_CHECK);
  endfunction

  // The core is held while loading and after a failed load, so it never
  // runs a partially loaded or corrupt program.
  function automatic logic state_hold(input loader_state_t s);
    return state_busy(s) || (s == ST_ERROR);
  endfunction

  // Bytes are taken while assembling program words or the checksum word.
  function automatic logic state_ready(input loader_state_t s);
    return (s == ST_RECV) || (s == ST_CHECK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : byte_word_assembler
//  Description : Packs a little-endian byte stream into 32-bit words. The
//                first byte of a word lands in bits 7:0. The word presented
//                on 'word' already contains the byte being accepted this
//                cycle, so the owner can capture a complete word on the
//                same edge that takes the 4th byte.
//  Ports       : clock, reset (async, active low)
//                clear      - discard any partial word, restart at lane 0
//                accept     - byte_in is taken this cycle
//                byte_in    - stream byte
//                word       - lanes merged with the byte at the current lane
//                word_full  - this accept completes a word
//  Revision    : 1.0  initial release
// ============================================================================
module byte_word_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [31:0] r_lanes;
  logic [1:0]  r_index;
  logic [31:0] w_word;

  always_comb begin
    w_word = r_lanes;
    case (r_index)
      2'd0:    w_word[7:0]   = byte_in;
      2'd1:    w_word[15:8]  = byte_in;
      2'd2:    w_word[23:16] = byte_in;
      default: w_word[31:24] = byte_in;
    endcase
  end

  assign word      = w_word;
  assign word_full = accept && (r_index == 2'd3);

  // The index is 2 bits, so it returns to lane 0 by itself after the 4th byte.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lanes <= 32'd0;
      r_index <= 2'd0;
    end else if (clear) begin
      r_lanes <= 32'd0;
      r_index <= 2'd0;
    end else if (accept) begin
      r_lanes <= w_word;
      r_index <= r_index + 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_stream_loader
//  Description : Run-time writer for the instruction memory. Takes a
//                little-endian byte stream over valid/ready, assembles
//                32-bit words, writes them to word addresses 0,1,2,... and
//                then checks a trailing XOR checksum word. The core is held
//                while a load runs and after a load fails.
//  Parameters  : ADDR_WIDTH - imem word-address width (2^ADDR_WIDTH words)
//                TIMEOUT    - idle cycles between bytes before abort
//  Ports       : clock, reset (async, active low)
//                load_start, load_words   - start pulse and program length
//                byte_in, byte_valid, byte_ready - byte stream handshake
//                imem_we, imem_addr, imem_wdata  - imem write port
//                cpu_hold, busy, done, error     - status
//  Revision    : 1.0  initial release
// ============================================================================
module imem_stream_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 1000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_words,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            error
);

  // The idle counter only has to hold TIMEOUT-1; the abort fires on the
  // idle cycle that would take it to TIMEOUT.
  localparam int                  c_tmo_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_tmo_w-1:0]  c_tmo_last = c_tmo_w'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH:0] c_depth    = {1'b1, {ADDR_WIDTH{1'b0}}};

  loader_state_t         r_state;
  loader_state_t         w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_wcount;
  logic [ADDR_WIDTH:0]   r_words;
  logic [ADDR_WIDTH:0]   w_wcount_inc;
  logic [31:0]           r_acc;
  logic [c_tmo_w-1:0]    r_tmo;
  logic [1:0]            r_error;
  logic [1:0]            w_err_next;
  logic                  r_imem_we;
  logic [ADDR_WIDTH-1:0] r_imem_addr;
  logic [31:0]           r_imem_wdata;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_hold;
  logic                  r_done;

  logic                  w_accept;
  logic                  w_start;
  logic                  w_timeout;
  logic                  w_tmo_hit;
  logic                  w_len_bad;
  logic                  w_len_zero;
  logic [31:0]           w_word;
  logic                  w_word_full;

  assign w_accept     = byte_valid && r_ready;
  assign w_tmo_hit    = !w_accept && (r_tmo == c_tmo_last);
  assign w_len_bad    = load_words > c_depth;
  assign w_len_zero   = (load_words == '0);
  assign w_wcount_inc = r_wcount + 1'b1;

  byte_word_assembler u_asm (
    .clock     (clock),
    .reset     (reset),
    .clear     (w_start | w_timeout),
    .accept    (w_accept),
    .byte_in   (byte_in),
    .word      (w_word),
    .word_full (w_word_full)
  );

  // word_full can only rise in RECV/CHECK because byte_ready is low elsewhere.
  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_timeout  = 1'b0;
    w_err_next = r_error;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (load_start) begin
          w_start    = 1'b1;
          w_err_next = ERR_NONE;
          if (w_len_bad) begin
            w_next     = ST_ERROR;
            w_err_next = ERR_LEN;
          end else if (w_len_zero) begin
            w_next = ST_CHECK;
          end else begin
            w_next = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (w_word_full) begin
          w_next = ST_WRITE;
        end else if (w_tmo_hit) begin
          w_next     = ST_ERROR;
          w_err_next = ERR_TIMEOUT;
          w_timeout  = 1'b1;
        end
      end
      ST_WRITE: begin
        w_next = (w_wcount_inc == r_words) ? ST_CHECK : ST_RECV;
      end
      ST_CHECK: begin
        if (w_word_full) begin
          if (w_word == r_acc) begin
            w_next = ST_DONE;
          end else begin
            w_next     = ST_ERROR;
            w_err_next = ERR_CSUM;
          end
        end else if (w_tmo_hit) begin
          w_next     = ST_ERROR;
          w_err_next = ERR_TIMEOUT;
          w_timeout  = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_wcount     <= '0;
      r_words      <= '0;
      r_acc        <= 32'd0;
      r_tmo        <= '0;
      r_error      <= ERR_NONE;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= 32'd0;
      r_ready      <= 1'b0;
      r_busy       <= 1'b0;
      r_hold       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_error   <= w_err_next;
      // Status outputs are registered from the next state so they line up
      // with the state register and carry no input-to-output path.
      r_ready   <= state_ready(w_next);
      r_busy    <= state_busy(w_next);
      r_hold    <= state_hold(w_next);
      r_done    <= (w_next == ST_DONE);
      r_imem_we <= 1'b0;

      if (w_start) begin
        r_addr   <= '0;
        r_wcount <= '0;
        r_acc    <= 32'd0;
        r_tmo    <= '0;
        r_words  <= load_words;
      end else begin
        case (r_state)
          ST_RECV, ST_CHECK: begin
            if (w_accept || w_tmo_hit) begin
              r_tmo <= '0;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
            if ((r_state == ST_RECV) && w_word_full) begin
              r_imem_we    <= 1'b1;
              r_imem_addr  <= r_addr;
              r_imem_wdata <= w_word;
            end
          end
          ST_WRITE: begin
            r_acc    <= r_acc ^ r_imem_wdata;
            // On a full-depth load this wraps to 0 after the last write;
            // it is not used again before the next start clears it.
            r_addr   <= r_addr + 1'b1;
            r_wcount <= w_wcount_inc;
          end
          default: ;
        endcase
      end
    end
  end

  assign byte_ready = r_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign cpu_hold   = r_hold;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_imem_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_stream_loader
//  Description : Self-checking bench for imem_stream_loader. A stream-level
//                model (bytes consumed, idle count, running XOR) predicts
//                every output each cycle; directed loads add literal checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_stream_loader;

  localparam int AW  = 8;
  localparam int TMO = 16;

  logic          clock;
  logic          reset;
  logic          load_start;
  logic [AW:0]   load_words;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic [1:0]    error;

  imem_stream_loader #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_start (load_start),
    .load_words (load_words),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;

  // Stream-level model: status 0 idle, 1 loading, 2 done, 3 failed.
  int          m_status;
  bit          m_wr;
  int          m_nbytes;
  int          m_words;
  int          m_idle;
  int          m_waddr;
  logic [31:0] m_word;
  logic [31:0] m_wdata;
  logic [31:0] m_csum;
  logic [1:0]  m_err;

  logic [31:0] prog    [0:255];
  logic [31:0] wr_data [0:299];
  int          wr_addr [0:299];
  int          wr_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_status = 0; m_wr = 0; m_nbytes = 0; m_words = 0; m_idle = 0;
    m_waddr = 0; m_word = 0; m_wdata = 0; m_csum = 0; m_err = 2'b00;
  endtask

  // Effect of the coming rising edge, from the inputs held across it.
  task automatic model_step();
    if (!reset) begin
      model_reset();
    end else if (m_status != 1) begin
      if (load_start) begin
        m_err = 2'b00; m_nbytes = 0; m_word = 0; m_csum = 0; m_idle = 0; m_wr = 0;
        m_words = int'(load_words);
        if (m_words > (1 << AW)) begin m_status = 3; m_err = 2'b11; end
        else m_status = 1;
      end
    end else if (m_wr) begin
      m_wr = 0;
    end else if (byte_valid) begin
      m_word[8*(m_nbytes%4) +: 8] = byte_in;
      m_nbytes++;
      m_idle = 0;
      if (m_nbytes % 4 == 0) begin
        if (m_nbytes <= 4 * m_words) begin
          m_wr    = 1;
          m_waddr = (m_nbytes / 4 - 1) % (1 << AW);
          m_wdata = m_word;
          m_csum  = m_csum ^ m_word;
        end else if (m_word == m_csum) begin
          m_status = 2;
        end else begin
          m_status = 3; m_err = 2'b01;
        end
        m_word = 0;
      end
    end else begin
      m_idle++;
      if (m_idle == TMO) begin m_status = 3; m_err = 2'b10; end
    end
  endtask

  task automatic compare();
    check("byte_ready", {31'b0, byte_ready}, {31'b0, (m_status == 1) && !m_wr});
    check("imem_we",    {31'b0, imem_we},    {31'b0, m_wr});
    if (m_wr) begin
      check("imem_addr",  {24'b0, imem_addr}, m_waddr);
      check("imem_wdata", imem_wdata, m_wdata);
    end
    check("cpu_hold", {31'b0, cpu_hold}, {31'b0, (m_status == 1) || (m_status == 3)});
    check("busy",     {31'b0, busy},     {31'b0, m_status == 1});
    check("done",     {31'b0, done},     {31'b0, m_status == 2});
    check("error",    {30'b0, error},    {30'b0, m_err});
    if (imem_we && wr_n < 300) begin
      wr_addr[wr_n] = int'(imem_addr);
      wr_data[wr_n] = imem_wdata;
      wr_n++;
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clock);
    compare();
  endtask

  task automatic start(input int n);
    wr_n       = 0;
    load_start = 1'b1;
    load_words = (AW+1)'(n);
    tick();
    load_start = 1'b0;
  endtask

  // Present one byte, hold it until the loader takes it; optionally pulse
  // load_start in the first cycle of this byte.
  task automatic send_byte(input logic [7:0] b, input bit pulse);
    int n;
    n          = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    if (pulse) begin load_start = 1'b1; load_words = 9'd5; end
    while (!byte_ready && n < 50) begin
      tick();
      load_start = 1'b0;
      n++;
    end
    check("byte_wait", {31'b0, byte_ready}, 32'd1);
    tick();
    load_start = 1'b0;
    byte_valid = 1'b0;
  endtask

  task automatic run_load(input int nw, input logic [31:0] csum, input int gapmax, input int pulse_at);
    logic [31:0] w;
    start(nw);
    for (int i = 0; i <= nw; i++) begin
      w = (i < nw) ? prog[i] : csum;
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8], (4*i + b) == pulse_at);
        repeat ($urandom_range(gapmax, 0)) tick();
      end
    end
    repeat (2) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {31'b0, byte_ready}, 32'd0);
    check({tag, "_we"},    {31'b0, imem_we},    32'd0);
    check({tag, "_addr"},  {24'b0, imem_addr},  32'd0);
    check({tag, "_wdata"}, imem_wdata,          32'd0);
    check({tag, "_hold"},  {31'b0, cpu_hold},   32'd0);
    check({tag, "_busy"},  {31'b0, busy},       32'd0);
    check({tag, "_done"},  {31'b0, done},       32'd0);
    check({tag, "_err"},   {30'b0, error},      32'd0);
  endtask

  initial begin
    int          n;
    bit          saw_ready;
    logic [31:0] cs;

    reset = 1'b0; load_start = 1'b0; load_words = '0;
    byte_in = 8'h00; byte_valid = 1'b0; wr_n = 0;
    model_reset();
    repeat (3) tick();
    check_all_zero("rst");
    reset = 1'b1;
    tick();

    // Good load: B #24, BL #8, checksum 0x80000004.
    prog[0] = 32'h14000006;
    prog[1] = 32'h94000002;
    run_load(2, 32'h80000004, 0, -1);
    check("t1_nwr",   wr_n, 32'd2);
    check("t1_a0",    wr_addr[0], 32'd0);
    check("t1_w0",    wr_data[0], 32'h14000006);
    check("t1_a1",    wr_addr[1], 32'd1);
    check("t1_w1",    wr_data[1], 32'h94000002);
    check("t1_mcsum", m_csum, 32'h80000004);
    check("t1_done",  {31'b0, done}, 32'd1);
    check("t1_hold",  {31'b0, cpu_hold}, 32'd0);
    check("t1_err",   {30'b0, error}, 32'd0);

    // Same program, wrong checksum.
    run_load(2, 32'h80000005, 0, -1);
    check("t2_nwr",  wr_n, 32'd2);
    check("t2_err",  {30'b0, error}, 32'd1);
    check("t2_hold", {31'b0, cpu_hold}, 32'd1);
    check("t2_done", {31'b0, done}, 32'd0);

    // Stream stalls after 2 bytes of word 1.
    start(2);
    for (int b = 0; b < 4; b++) send_byte(prog[0][8*b +: 8], 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    n = 0;
    while (error !== 2'b10 && n < 40) begin tick(); n++; end
    check("t3_idle_cycles", n, 32'd16);
    check("t3_nwr", wr_n, 32'd1);
    check("t3_hold", {31'b0, cpu_hold}, 32'd1);
    repeat (3) tick();

    // Zero-length program, checksum 0.
    run_load(0, 32'h00000000, 0, -1);
    check("t4_nwr",  wr_n, 32'd0);
    check("t4_done", {31'b0, done}, 32'd1);
    check("t4_err",  {30'b0, error}, 32'd0);

    // Length one past the memory depth.
    start(257);
    saw_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (byte_ready) saw_ready = 1'b1;
      tick();
    end
    check("t5_err",   {30'b0, error}, 32'd3);
    check("t5_merr",  {30'b0, m_err}, 32'd3);
    check("t5_ready", {31'b0, saw_ready}, 32'd0);
    check("t5_hold",  {31'b0, cpu_hold}, 32'd1);

    // Random gaps with a stray start pulse in the middle of word 1.
    prog[0] = 32'hDEADBEEF; prog[1] = 32'h01234567; prog[2] = 32'h89ABCDEF;
    prog[3] = 32'h0F0F00FF; prog[4] = 32'hA5A55A5A;
    cs = 32'h0;
    for (int i = 0; i < 5; i++) cs = cs ^ prog[i];
    run_load(5, cs, 3, 6);
    check("t6_nwr",  wr_n, 32'd5);
    check("t6_w1",   wr_data[1], 32'h01234567);
    check("t6_a4",   wr_addr[4], 32'd4);
    check("t6_w4",   wr_data[4], 32'hA5A55A5A);
    check("t6_done", {31'b0, done}, 32'd1);

    // Reset mid-word, then a good load.
    start(3);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    reset = 1'b0;
    model_reset();
    #1;
    check_all_zero("t7");
    repeat (2) tick();
    reset = 1'b1;
    tick();
    prog[0] = 32'h14000006;
    prog[1] = 32'h94000002;
    run_load(2, 32'h80000004, 0, -1);
    check("t7_nwr",  wr_n, 32'd2);
    check("t7_w1",   wr_data[1], 32'h94000002);
    check("t7_done", {31'b0, done}, 32'd1);

    // Full-depth load: last write at address 255.
    cs = 32'h0;
    for (int i = 0; i < 256; i++) begin
      prog[i] = {i[7:0], 8'h5A, ~i[7:0], 8'h3C};
      cs = cs ^ prog[i];
    end
    run_load(256, cs, 0, -1);
    check("t8_nwr",   wr_n, 32'd256);
    check("t8_a255",  wr_addr[255], 32'd255);
    check("t8_w255",  wr_data[255], 32'hFF5A003C);
    check("t8_done",  {31'b0, done}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
